// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and helpers for the 64-point FFT datapath.
//   FFT_N        default FFT length
//   FFT_DATA_WD  default bit width of each real/imag sample
//   WN_IDX_WD    default twiddle index width, log2(FFT_N/2)
//   fft_clog2()  ceiling log2 for elaboration-time width calculations
package fft_pkg;

  function automatic int fft_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int FFT_N       = 64;
  localparam int FFT_DATA_WD = 10;
  localparam int WN_IDX_WD   = fft_clog2(FFT_N / 2);

endpackage

// File: rtl/fft_pair_buf.sv
// fft_pair_buf: DEPTH-entry complex sample store for the pair feeder.
// Holds the first half of a butterfly block until the partner samples
// arrive. Write is synchronous, read is combinational, so the store can
// later be swapped for a RAM with asynchronous read on large spans.
//   clk          clock, rising edge
//   wr_en        write strobe for entry addr
//   addr         shared write/read address
//   wr_re/wr_im  sample to store
//   rd_re/rd_im  sample currently held at addr
// Contents are intentionally not reset.
module fft_pair_buf
  import fft_pkg::*;
#(
  parameter int FFT_DATA_WD = fft_pkg::FFT_DATA_WD,
  parameter int DEPTH       = 32,
  parameter int ADDR_WD     = 5
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [ADDR_WD-1:0]            addr,
  input  logic signed [FFT_DATA_WD-1:0] wr_re,
  input  logic signed [FFT_DATA_WD-1:0] wr_im,
  output logic signed [FFT_DATA_WD-1:0] rd_re,
  output logic signed [FFT_DATA_WD-1:0] rd_im
);

  logic [2*FFT_DATA_WD-1:0] mem [DEPTH];

  generate
    if (DEPTH == 1) begin : g_single
      // A one-entry store has no meaningful address.
      always_ff @(posedge clk) begin
        if (wr_en) mem[0] <= {wr_re, wr_im};
      end
      assign {rd_re, rd_im} = mem[0];
    end else begin : g_array
      always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= {wr_re, wr_im};
      end
      assign {rd_re, rd_im} = mem[addr];
    end
  endgenerate

endmodule

// File: rtl/fft_pair_feeder.sv
// fft_pair_feeder: operand pairing front end for one radix-2 FFT stage.
// Buffers the first STG_SPAN samples of every 2*STG_SPAN block (FILL),
// then pairs each buffered x[k] with the arriving x[k+STG_SPAN] (PAIR) and
// presents the pair with its twiddle index through a one-deep output
// register. Samples pass through bit-exact.
//   clk, rst_n                 clock, synchronous active-low reset
//   din_vld/din_rdy            input sample handshake
//   din_re/din_im              input complex sample
//   dout_vld/dout_rdy          operand pair handshake
//   dout_1_re/dout_1_im        upper operand x[k]
//   dout_2_re/dout_2_im        lower operand x[k+STG_SPAN]
//   dout_wn_idx                twiddle index k*TW_STEP
//   dout_last                  final pair of a block (k = STG_SPAN-1)
module fft_pair_feeder
  import fft_pkg::*;
#(
  parameter int FFT_DATA_WD = fft_pkg::FFT_DATA_WD,
  parameter int FFT_N       = fft_pkg::FFT_N,
  parameter int STG_SPAN    = 32,
  parameter int WN_IDX_WD   = fft_pkg::WN_IDX_WD
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          din_vld,
  output logic                          din_rdy,
  input  logic signed [FFT_DATA_WD-1:0] din_re,
  input  logic signed [FFT_DATA_WD-1:0] din_im,
  output logic                          dout_vld,
  input  logic                          dout_rdy,
  output logic signed [FFT_DATA_WD-1:0] dout_1_re,
  output logic signed [FFT_DATA_WD-1:0] dout_1_im,
  output logic signed [FFT_DATA_WD-1:0] dout_2_re,
  output logic signed [FFT_DATA_WD-1:0] dout_2_im,
  output logic [WN_IDX_WD-1:0]          dout_wn_idx,
  output logic                          dout_last
);

  localparam int TW_STEP = FFT_N / (2 * STG_SPAN);
  localparam int CNT_WD  = (fft_clog2(STG_SPAN) < 1) ? 1 : fft_clog2(STG_SPAN);
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(STG_SPAN - 1);

  typedef enum logic {FILL, PAIR} stage_e;

  stage_e                        state;
  logic [CNT_WD-1:0]             cnt;
  logic                          in_xfer;
  logic                          cnt_last;
  logic signed [FFT_DATA_WD-1:0] buf_re;
  logic signed [FFT_DATA_WD-1:0] buf_im;

  function automatic logic [WN_IDX_WD-1:0] wn_idx_of(input logic [CNT_WD-1:0] k);
    logic [31:0] prod;
    prod = 32'(k) * 32'(TW_STEP);
    return prod[WN_IDX_WD-1:0];
  endfunction

  // FILL never touches the output register, so it keeps accepting samples
  // even while the previous block's last pair is stalled downstream.
  assign din_rdy  = rst_n & ((state == FILL) | ~dout_vld | dout_rdy);
  assign in_xfer  = din_vld & din_rdy;
  assign cnt_last = (cnt == CNT_LAST);

  fft_pair_buf #(
    .FFT_DATA_WD (FFT_DATA_WD),
    .DEPTH       (STG_SPAN),
    .ADDR_WD     (CNT_WD)
  ) u_buf (
    .clk   (clk),
    .wr_en (in_xfer & (state == FILL)),
    .addr  (cnt),
    .wr_re (din_re),
    .wr_im (din_im),
    .rd_re (buf_re),
    .rd_im (buf_im)
  );

  // ---- stage boundary: accepted lower sample -> registered operand pair ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FILL;
      cnt         <= '0;
      dout_vld    <= 1'b0;
      dout_1_re   <= '0;
      dout_1_im   <= '0;
      dout_2_re   <= '0;
      dout_2_im   <= '0;
      dout_wn_idx <= '0;
      dout_last   <= 1'b0;
    end else begin
      if (in_xfer) begin
        cnt <= cnt_last ? '0 : cnt + CNT_WD'(1);
        if (cnt_last) state <= (state == FILL) ? PAIR : FILL;
      end
      if (in_xfer && state == PAIR) begin
        dout_1_re   <= buf_re;
        dout_1_im   <= buf_im;
        dout_2_re   <= din_re;
        dout_2_im   <= din_im;
        dout_wn_idx <= wn_idx_of(cnt);
        dout_last   <= cnt_last;
        dout_vld    <= 1'b1;
      end else if (dout_rdy) begin
        dout_vld <= 1'b0;
      end
    end
  end

endmodule
